// File: rtl/mor1kx_branch_resolver_pkg.sv
// Shared encodings for the branch resolver: FSM states and PC step sizes.
// Combinational content only; no latency or backpressure of its own.
package mor1kx_branch_resolver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_REDIRECT = 2'd2
    } br_state_t;

    localparam int unsigned PC_STEP_INSN = 4;
    localparam int unsigned PC_STEP_DS   = 8;

    // With a delay slot the fall-through skips both the branch and its slot.
    function automatic int unsigned fallthrough_step(input logic delay_slot_en);
        return delay_slot_en ? PC_STEP_DS : PC_STEP_INSN;
    endfunction

endpackage

// File: rtl/mor1kx_branch_resolver_if.sv
// Decode/execute/fetch signal bundle of the branch resolver; slave = resolver side.
// Pure wiring; no latency, backpressure carried by stall_decode_o and redirect_ack_i.
interface mor1kx_branch_resolver_if #(
    parameter int OW = 32,
    parameter int CW = 16
);
    logic          padv_decode_i;
    logic          op_bf_i;
    logic          op_bnf_i;
    logic          predicted_flag_i;
    logic [OW-1:0] pc_decode_i;
    logic [OW-1:0] branch_target_i;
    logic          flag_valid_i;
    logic          execute_flag_i;
    logic          pipeline_flush_i;
    logic          redirect_ack_i;
    logic          stall_decode_o;
    logic          branch_mispredict_o;
    logic [OW-1:0] mispredict_npc_o;
    logic [CW-1:0] branch_count_o;
    logic [CW-1:0] mispredict_count_o;

    modport slave (
        input  padv_decode_i, op_bf_i, op_bnf_i, predicted_flag_i,
        input  pc_decode_i, branch_target_i, flag_valid_i, execute_flag_i,
        input  pipeline_flush_i, redirect_ack_i,
        output stall_decode_o, branch_mispredict_o, mispredict_npc_o,
        output branch_count_o, mispredict_count_o
    );

    modport master (
        output padv_decode_i, op_bf_i, op_bnf_i, predicted_flag_i,
        output pc_decode_i, branch_target_i, flag_valid_i, execute_flag_i,
        output pipeline_flush_i, redirect_ack_i,
        input  stall_decode_o, branch_mispredict_o, mispredict_npc_o,
        input  branch_count_o, mispredict_count_o
    );
endinterface

// File: rtl/mor1kx_sat_counter.sv
// Saturating up-counter, cleared by synchronous active-low reset.
// Count visible one cycle after inc_i; never backpressures, sticks at all-ones.
module mor1kx_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/mor1kx_branch_resolver.sv
// Resolves predicted l.bf/l.bnf against SR[F]; redirect appears the cycle after flag_valid_i.
// Stalls decode while a redirect is outstanding or the entry is still unresolved; redirect held until ack.
module mor1kx_branch_resolver
    import mor1kx_branch_resolver_pkg::*;
#(
    parameter int    OPTION_OPERAND_WIDTH = 32,
    parameter string FEATURE_DELAY_SLOT   = "ENABLED",
    parameter int    COUNTER_WIDTH        = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mor1kx_branch_resolver_if.slave   bus
);
    localparam int OW = OPTION_OPERAND_WIDTH;
    localparam bit DS_EN = (FEATURE_DELAY_SLOT == "ENABLED");
    localparam logic [OW-1:0] FT_STEP = OW'(fallthrough_step(DS_EN));

    br_state_t     state_q;
    logic          bf_q;
    logic          bnf_q;
    logic          pred_q;
    logic [OW-1:0] pc_q;
    logic [OW-1:0] target_q;
    logic [OW-1:0] npc_q;
    logic [OW-1:0] npc_d;

    logic branch_offered;
    logic stall;
    logic capture;
    logic resolve;
    logic taken;
    logic mismatch;
    logic entry_load;

    assign branch_offered = bus.padv_decode_i & (bus.op_bf_i | bus.op_bnf_i);
    assign stall = (state_q == ST_REDIRECT) |
                   ((state_q == ST_PENDING) & ~bus.flag_valid_i & branch_offered);
    assign capture  = branch_offered & ~stall;
    assign resolve  = (state_q == ST_PENDING) & bus.flag_valid_i & ~bus.pipeline_flush_i;
    assign taken    = (bf_q & bus.execute_flag_i) | (bnf_q & ~bus.execute_flag_i);
    assign mismatch = resolve & (taken != pred_q);
    assign npc_d    = taken ? target_q : pc_q + FT_STEP;
    // A branch decoded alongside a mispredict is on the wrong path, so it is not kept.
    assign entry_load = capture & ~mismatch & ~bus.pipeline_flush_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bf_q     <= 1'b0;
            bnf_q    <= 1'b0;
            pred_q   <= 1'b0;
            pc_q     <= '0;
            target_q <= '0;
        end else if (bus.pipeline_flush_i) begin
            bf_q     <= 1'b0;
            bnf_q    <= 1'b0;
            pred_q   <= 1'b0;
        end else if (entry_load) begin
            bf_q     <= bus.op_bf_i;
            bnf_q    <= bus.op_bnf_i & ~bus.op_bf_i;
            pred_q   <= bus.predicted_flag_i;
            pc_q     <= bus.pc_decode_i;
            target_q <= bus.branch_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            npc_q   <= '0;
        end else if (bus.pipeline_flush_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (capture) state_q <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (mismatch) begin
                        state_q <= ST_REDIRECT;
                        npc_q   <= npc_d;
                    end else if (resolve) begin
                        state_q <= capture ? ST_PENDING : ST_IDLE;
                    end
                end
                ST_REDIRECT: begin
                    if (bus.redirect_ack_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mor1kx_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_branch_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (resolve),
        .count_o (bus.branch_count_o)
    );

    mor1kx_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_mispredict_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (mismatch),
        .count_o (bus.mispredict_count_o)
    );

    assign bus.stall_decode_o      = stall;
    assign bus.branch_mispredict_o = (state_q == ST_REDIRECT);
    assign bus.mispredict_npc_o    = npc_q;
endmodule

// File: tb/tb_mor1kx_branch_resolver.sv
// Directed bench: three resolver builds (default, no delay slot, 2-bit counters) share one stimulus.
module tb_mor1kx_branch_resolver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        padv, bf, bnf, pred, fv, fl, flush, ack;
    logic [31:0] pc, tgt;
    int n_checks = 0;
    int n_fail   = 0;

    mor1kx_branch_resolver_if #(.OW(32), .CW(16)) if0 ();
    mor1kx_branch_resolver_if #(.OW(32), .CW(16)) if1 ();
    mor1kx_branch_resolver_if #(.OW(32), .CW(2))  if2 ();

    assign if0.padv_decode_i = padv;  assign if1.padv_decode_i = padv;  assign if2.padv_decode_i = padv;
    assign if0.op_bf_i = bf;          assign if1.op_bf_i = bf;          assign if2.op_bf_i = bf;
    assign if0.op_bnf_i = bnf;        assign if1.op_bnf_i = bnf;        assign if2.op_bnf_i = bnf;
    assign if0.predicted_flag_i = pred; assign if1.predicted_flag_i = pred; assign if2.predicted_flag_i = pred;
    assign if0.pc_decode_i = pc;      assign if1.pc_decode_i = pc;      assign if2.pc_decode_i = pc;
    assign if0.branch_target_i = tgt; assign if1.branch_target_i = tgt; assign if2.branch_target_i = tgt;
    assign if0.flag_valid_i = fv;     assign if1.flag_valid_i = fv;     assign if2.flag_valid_i = fv;
    assign if0.execute_flag_i = fl;   assign if1.execute_flag_i = fl;   assign if2.execute_flag_i = fl;
    assign if0.pipeline_flush_i = flush; assign if1.pipeline_flush_i = flush; assign if2.pipeline_flush_i = flush;
    assign if0.redirect_ack_i = ack;  assign if1.redirect_ack_i = ack;  assign if2.redirect_ack_i = ack;

    mor1kx_branch_resolver u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mor1kx_branch_resolver #(.FEATURE_DELAY_SLOT("NONE")) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mor1kx_branch_resolver #(.COUNTER_WIDTH(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        padv = 0; bf = 0; bnf = 0; pred = 0; fv = 0; fl = 0; flush = 0; ack = 0;
        pc = 32'h0; tgt = 32'h0;
    endtask

    task automatic offer(input logic is_bf, input logic p, input logic [31:0] a, input logic [31:0] t);
        padv = 1; bf = is_bf; bnf = ~is_bf; pred = p; pc = a; tgt = t;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        #1;
        n_checks++; if (if0.branch_mispredict_o !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict got %b want 0", if0.branch_mispredict_o); end
        n_checks++; if (if0.stall_decode_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", if0.stall_decode_o); end
        n_checks++; if (if0.mispredict_npc_o !== 32'h0) begin n_fail++; $display("FAIL reset_npc got %h want 0", if0.mispredict_npc_o); end
        n_checks++; if (if0.branch_count_o !== 16'd0 || if0.mispredict_count_o !== 16'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", if0.branch_count_o, if0.mispredict_count_o); end
    endtask

    task automatic test_correct_predict();
        offer(1, 1, 32'h100, 32'h0F0);
        tick();
        padv = 0; bf = 0; fv = 1; fl = 1;
        tick();
        fv = 0; fl = 0;
        n_checks++; if (if0.branch_mispredict_o !== 1'b0) begin n_fail++; $display("FAIL correct_no_mispredict got %b want 0", if0.branch_mispredict_o); end
        n_checks++; if (if0.branch_count_o !== 16'd1) begin n_fail++; $display("FAIL correct_branch_count got %0d want 1", if0.branch_count_o); end
        n_checks++; if (if0.mispredict_count_o !== 16'd0) begin n_fail++; $display("FAIL correct_mis_count got %0d want 0", if0.mispredict_count_o); end
    endtask

    task automatic test_mispredict_taken();
        offer(1, 0, 32'h200, 32'h180);
        tick();
        padv = 0; bf = 0; fv = 1; fl = 1;
        tick();
        fv = 0; fl = 0;
        #1;
        n_checks++; if (if0.branch_mispredict_o !== 1'b1) begin n_fail++; $display("FAIL taken_mispredict got %b want 1", if0.branch_mispredict_o); end
        n_checks++; if (if0.mispredict_npc_o !== 32'h180) begin n_fail++; $display("FAIL taken_npc got %h want 00000180", if0.mispredict_npc_o); end
        n_checks++; if (if0.stall_decode_o !== 1'b1) begin n_fail++; $display("FAIL taken_stall got %b want 1", if0.stall_decode_o); end
        n_checks++; if (if0.mispredict_count_o !== 16'd1 || if0.branch_count_o !== 16'd2) begin n_fail++; $display("FAIL taken_counts got %0d/%0d want 2/1", if0.branch_count_o, if0.mispredict_count_o); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (if0.branch_mispredict_o !== 1'b1 || if0.mispredict_npc_o !== 32'h180) begin n_fail++; $display("FAIL taken_hold%0d got %b/%h want 1/00000180", i, if0.branch_mispredict_o, if0.mispredict_npc_o); end
        end
        ack = 1;
        tick();
        ack = 0;
        n_checks++; if (if0.branch_mispredict_o !== 1'b0 || if0.stall_decode_o !== 1'b0) begin n_fail++; $display("FAIL taken_after_ack got %b/%b want 0/0", if0.branch_mispredict_o, if0.stall_decode_o); end
        n_checks++; if (if0.mispredict_count_o !== 16'd1) begin n_fail++; $display("FAIL taken_count_after_ack got %0d want 1", if0.mispredict_count_o); end
    endtask

    task automatic test_bnf_fallthrough();
        offer(0, 1, 32'h300, 32'h400);
        tick();
        padv = 0; bnf = 0; fv = 1; fl = 1;
        tick();
        fv = 0; fl = 0;
        n_checks++; if (if0.mispredict_npc_o !== 32'h308) begin n_fail++; $display("FAIL bnf_npc_ds got %h want 00000308", if0.mispredict_npc_o); end
        n_checks++; if (if1.mispredict_npc_o !== 32'h304) begin n_fail++; $display("FAIL bnf_npc_nods got %h want 00000304", if1.mispredict_npc_o); end
        n_checks++; if (if1.branch_mispredict_o !== 1'b1) begin n_fail++; $display("FAIL bnf_mispredict got %b want 1", if1.branch_mispredict_o); end
        ack = 1;
        tick();
        ack = 0;
    endtask

    task automatic test_flag_late_back_to_back();
        offer(1, 1, 32'h500, 32'h480);
        tick();
        offer(1, 1, 32'h600, 32'h580);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (if0.stall_decode_o !== 1'b1) begin n_fail++; $display("FAIL late_stall%0d got %b want 1", i, if0.stall_decode_o); end
            n_checks++; if (if0.branch_count_o !== 16'd3) begin n_fail++; $display("FAIL late_count%0d got %0d want 3", i, if0.branch_count_o); end
            tick();
        end
        fv = 1; fl = 1;
        #1;
        n_checks++; if (if0.stall_decode_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_release got %b want 0", if0.stall_decode_o); end
        tick();
        padv = 0; bf = 0; fl = 0;
        n_checks++; if (if0.branch_count_o !== 16'd4 || if0.branch_mispredict_o !== 1'b0) begin n_fail++; $display("FAIL late_resolve_once got %0d/%b want 4/0", if0.branch_count_o, if0.branch_mispredict_o); end
        tick();
        fv = 0;
        n_checks++; if (if0.branch_mispredict_o !== 1'b1 || if0.mispredict_npc_o !== 32'h608) begin n_fail++; $display("FAIL b2b_second got %b/%h want 1/00000608", if0.branch_mispredict_o, if0.mispredict_npc_o); end
        n_checks++; if (if0.branch_count_o !== 16'd5 || if0.mispredict_count_o !== 16'd3) begin n_fail++; $display("FAIL b2b_counts got %0d/%0d want 5/3", if0.branch_count_o, if0.mispredict_count_o); end
    endtask

    task automatic test_flush_redirect();
        flush = 1; ack = 1;
        tick();
        flush = 0; ack = 0;
        n_checks++; if (if0.branch_mispredict_o !== 1'b0 || if0.stall_decode_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle got %b/%b want 0/0", if0.branch_mispredict_o, if0.stall_decode_o); end
        n_checks++; if (if0.branch_count_o !== 16'd5 || if0.mispredict_count_o !== 16'd3) begin n_fail++; $display("FAIL flush_counts got %0d/%0d want 5/3", if0.branch_count_o, if0.mispredict_count_o); end
        fv = 1; fl = 1;
        tick();
        fv = 0; fl = 0;
        n_checks++; if (if0.branch_count_o !== 16'd5) begin n_fail++; $display("FAIL idle_flag_ignored got %0d want 5", if0.branch_count_o); end
    endtask

    task automatic test_reset_pending();
        offer(1, 0, 32'h700, 32'h680);
        tick();
        padv = 0; bf = 0;
        rst_n = 0; fv = 1; fl = 1;
        tick();
        rst_n = 1; fv = 0; fl = 0;
        n_checks++; if (if0.branch_mispredict_o !== 1'b0 || if0.stall_decode_o !== 1'b0) begin n_fail++; $display("FAIL rst_pending_idle got %b/%b want 0/0", if0.branch_mispredict_o, if0.stall_decode_o); end
        n_checks++; if (if0.branch_count_o !== 16'd0 || if0.mispredict_count_o !== 16'd0) begin n_fail++; $display("FAIL rst_pending_counts got %0d/%0d want 0/0", if0.branch_count_o, if0.mispredict_count_o); end
        tick();
        n_checks++; if (if0.branch_mispredict_o !== 1'b0) begin n_fail++; $display("FAIL rst_pending_no_pulse got %b want 0", if0.branch_mispredict_o); end
    endtask

    task automatic test_saturate_wrap();
        for (int i = 0; i < 5; i++) begin
            offer(1, 1, 32'hFFFF_FFFC, 32'h1000);
            tick();
            padv = 0; bf = 0; fv = 1; fl = 0;
            tick();
            fv = 0;
            n_checks++; if (if2.branch_mispredict_o !== 1'b1 || if2.mispredict_npc_o !== 32'h4) begin n_fail++; $display("FAIL wrap_npc%0d got %b/%h want 1/00000004", i, if2.branch_mispredict_o, if2.mispredict_npc_o); end
            ack = 1;
            tick();
            ack = 0;
        end
        n_checks++; if (if1.mispredict_npc_o !== 32'h0) begin n_fail++; $display("FAIL wrap_npc_nods got %h want 00000000", if1.mispredict_npc_o); end
        n_checks++; if (if2.mispredict_count_o !== 2'd3 || if2.branch_count_o !== 2'd3) begin n_fail++; $display("FAIL sat_counts got %0d/%0d want 3/3", if2.branch_count_o, if2.mispredict_count_o); end
        n_checks++; if (if0.mispredict_count_o !== 16'd5 || if0.branch_count_o !== 16'd5) begin n_fail++; $display("FAIL wide_counts got %0d/%0d want 5/5", if0.branch_count_o, if0.mispredict_count_o); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_correct_predict();
        test_mispredict_taken();
        test_bnf_fallthrough();
        test_flag_late_back_to_back();
        test_flush_redirect();
        test_reset_pending();
        test_saturate_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
